tlb_miss_walk_arbiter: RTL

Shares the single page-table walker (PTW) between the instruction-TLB and data-TLB miss paths of the sv39 MMU. Accepts one outstanding miss at a time, presents it to the PTW with a valid/ready handshake, and routes the completion back to the owning TLB. Sits between the ITLB/DTLB miss outputs and the PTW request port inside the MMU. Handles flushes (SFENCE.VMA) mid-walk and bounds ITLB starvation under DTLB miss storms.

---
 rtl/tlb_miss_walk_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/tlb_miss_walk_arbiter.sv
// Arbitrates ITLB/DTLB misses onto the single sv39 page-table walker and routes completions back.
// Define TLB_ARB_ANTISTARVE_EN to bound ITLB starvation to StarveMax consecutive DTLB grants.
module tlb_miss_walk_arbiter #(
  parameter int unsigned VpnWidth  = 27,
  parameter int unsigned StarveMax = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic                itlb_req_i,
  input  logic [VpnWidth-1:0] itlb_vpn_i,
  output logic                itlb_gnt_o,
  output logic                itlb_done_o,
  input  logic                dtlb_req_i,
  input  logic [VpnWidth-1:0] dtlb_vpn_i,
  input  logic                dtlb_is_store_i,
  output logic                dtlb_gnt_o,
  output logic                dtlb_done_o,
  output logic                walk_valid_o,
  input  logic                walk_ready_i,
  output logic [VpnWidth-1:0] walk_vpn_o,
  output logic                walk_is_instr_o,
  output logic                walk_is_store_o,
  input  logic                walk_done_i,
  input  logic                walk_err_i,
  output logic                resp_err_o,
  output logic                busy_o
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WALK,
    FLUSH_WAIT
  } state_e;

  state_e              state_q, state_d;
  logic [VpnWidth-1:0] vpn_q;
  logic                is_instr_q;
  logic                is_store_q;
  logic                grant_ok;
  logic                itlb_win;
  logic                walk_finish;

  if (StarveMax < 1) begin : g_starve_max_check
    $error("StarveMax must be at least 1");
  end

  // Grants only issue from IDLE, and never while a flush is in progress.
  assign grant_ok = (state_q == IDLE) && !flush_i;

`ifdef TLB_ARB_ANTISTARVE_EN
  localparam int unsigned CntWidth = $clog2(StarveMax + 1);

  logic [CntWidth-1:0] starve_q;
  logic                itlb_boost;

  assign itlb_boost = (starve_q == CntWidth'(StarveMax));
  assign itlb_win   = itlb_req_i && (!dtlb_req_i || itlb_boost);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      starve_q <= '0;
    end else if (flush_i || itlb_gnt_o) begin
      starve_q <= '0;
    end else if (dtlb_gnt_o && itlb_req_i && !itlb_boost) begin
      starve_q <= starve_q + 1'b1;
    end
  end
`else
  assign itlb_win = itlb_req_i && !dtlb_req_i;
`endif

  assign itlb_gnt_o = grant_ok && itlb_win;
  assign dtlb_gnt_o = grant_ok && dtlb_req_i && !itlb_win;

  // A completion is delivered only from WALK; a coincident flush swallows it.
  assign walk_finish = (state_q == WALK) && walk_done_i && !flush_i;

  assign itlb_done_o     = walk_finish && is_instr_q;
  assign dtlb_done_o     = walk_finish && !is_instr_q;
  assign resp_err_o      = walk_finish && walk_err_i;
  assign walk_valid_o    = (state_q == REQ);
  assign busy_o          = (state_q != IDLE);
  assign walk_vpn_o      = vpn_q;
  assign walk_is_instr_o = is_instr_q;
  assign walk_is_store_o = is_store_q;

  always_comb begin
    // NOTE: next state defaults to the current state so every path assigns it; no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (itlb_gnt_o || dtlb_gnt_o) state_d = REQ;
      end
      REQ: begin
        if (flush_i)           state_d = walk_ready_i ? FLUSH_WAIT : IDLE;
        else if (walk_ready_i) state_d = WALK;
      end
      WALK: begin
        if (walk_done_i)  state_d = IDLE;
        else if (flush_i) state_d = FLUSH_WAIT;
      end
      FLUSH_WAIT: begin
        if (walk_done_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: reset is synchronous, so it is tested inside the clocked block; all state uses <=.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request payload is captured on the grant and held until the next grant.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vpn_q      <= '0;
      is_instr_q <= 1'b0;
      is_store_q <= 1'b0;
    end else if (itlb_gnt_o) begin
      vpn_q      <= itlb_vpn_i;
      is_instr_q <= 1'b1;
      is_store_q <= 1'b0;
    end else if (dtlb_gnt_o) begin
      vpn_q      <= dtlb_vpn_i;
      is_instr_q <= 1'b0;
      is_store_q <= dtlb_is_store_i;
    end
  end

endmodule
